fetch_queue: RTL

- Decoupling FIFO between fetch (PC / instruction queue / predictor lookup) and decode_pipeline.
- Each entry carries the fetched instruction, its PC, and the front-end prediction made for it (taken bit and BTB target), so decode/execute see exactly what fetch assumed.
- Execute's flush_pipeline empties the queue on a mispredict. Fetch stalls via ready/valid backpressure when the queue is full.

---
 rtl/fetch_queue.sv | 101 ++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Fetch-to-decode FIFO carrying instr, PC and front-end prediction;
//            flushable on mispredict with a saturating dropped-entry counter.
// Revision : 1.0
// ============================================================================
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int AW     = $clog2(DEPTH),
    parameter int DROP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [31:0]       in_pc,
    input  logic              in_pred_taken,
    input  logic [31:0]       in_pred_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc,
    output logic              out_pred_taken,
    output logic [31:0]       out_pred_target,
    output logic [AW:0]       count,
    output logic [DROP_W-1:0] flush_drops
);

    localparam int              c_EW       = 97;
    localparam int              c_SW       = DROP_W + AW + 2;
    localparam logic [AW:0]     c_FULL     = (AW+1)'(DEPTH);
    localparam logic [DROP_W-1:0] c_DROP_MAX = '1;

    logic [c_EW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]     r_wp;
    logic [AW-1:0]     r_rp;
    logic [AW:0]       r_cnt;
    logic [DROP_W-1:0] r_drops;

    logic              w_push;
    logic              w_pop;
    logic [c_EW-1:0]   w_head;
    logic [c_SW-1:0]   w_sum;
    logic [DROP_W-1:0] w_drops_next;

    assign in_ready  = (r_cnt != c_FULL);
    assign out_valid = (r_cnt != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // An empty queue presents all zeros so decode sees a NOP.
    assign w_head = out_valid ? r_mem[r_rp] : '0;
    assign {out_pred_taken, out_pred_target, out_pc, out_instr} = w_head;

    assign count       = r_cnt;
    assign flush_drops = r_drops;

    assign w_sum        = c_SW'(r_drops) + c_SW'(r_cnt);
    assign w_drops_next = (w_sum > c_SW'(c_DROP_MAX)) ? c_DROP_MAX : w_sum[DROP_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst && !flush && w_push) begin
            r_mem[r_wp] <= {in_pred_taken, in_pred_target, in_pc, in_instr};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
            r_drops <= '0;
        end else if (flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
            r_drops <= w_drops_next;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    a_cnt_bound: assert property (@(posedge clk) disable iff (rst) r_cnt <= c_FULL);
    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(w_push && r_cnt == c_FULL));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(w_pop && r_cnt == '0));

endmodule
`default_nettype wire
